score_engine: RTL and testbench
===============================

SCORE_ENGINE -- requirements
Module: score_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SCORE_W, 14, width of points/best (>=14).
  CARDS_W, 6, width of num_of_cards.
  PAIRS_W, 8, width of discovered_pairs.
  SEC_W, 6, width of seconds.
  PENALTY, 101, points deducted per excess second / excess pair.
  MAX_PART, 3333, ceiling of each partial score.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, clock.
  rst, in, 1, synchronous active-high reset.
  start, in, 1, level request: compute score.
  level, in, 2, 0 easy, 1 normal, 2 hard, 3 invalid.
  num_of_cards, in, CARDS_W, cards on board.
  discovered_pairs, in, PAIRS_W, pair attempts made.
  seconds, in, SEC_W, game time.
  busy, out, 1, computation in progress.
  done, out, 1, one-cycle completion pulse.
  points, out, SCORE_W, final score.
  best, out, SCORE_W, best score since reset.
  new_record, out, 1, qualifies done.
REQ-003 Reset rst SHALL be synchronous, active-high; clock clk; all state changes on posedge clk.

Function
REQ-004 States SHALL be IDLE, LOAD, TIME_PEN, PAIR_PEN, SUM, DONE, WAIT.
REQ-005 IDLE: start=1 sampled at edge k -> LOAD; all inputs latched at that edge; later input changes ignored until WAIT exits.
REQ-006 LOAD (1 cycle): grace = 0/5/10 s for level 0/1/2; excess_t = seconds-grace, or 0 if seconds<=grace; excess_p = discovered_pairs-num_of_cards/2, or 0 if below; bonus = 0/1515/3333 for level 0/1/2.
REQ-007 TIME_PEN SHALL last Nt = max(1, min(excess_t, LIMIT)) cycles, LIMIT = ceil(MAX_PART/PENALTY) (33 at defaults), adding PENALTY to a penalty accumulator once per excess second; no multiplier used.
REQ-008 time_score = MAX_PART - min(acc, MAX_PART); saturates at 0, never wraps.
REQ-009 PAIR_PEN SHALL likewise last Np = max(1, min(excess_p, LIMIT)) cycles; pair_score = MAX_PART - min(acc_p, MAX_PART).
REQ-010 level=3: bonus=0, time_score=0; pair_score computed normally.
REQ-011 SUM (1 cycle): total = bonus + time_score + pair_score (max 9999, no overflow at SCORE_W>=14).
REQ-012 DONE: done=1 and points=total during cycle k+3+Nt+Np only; then WAIT.
REQ-013 points SHALL hold its last value until the next DONE; unchanged during a new computation.
REQ-014 busy=1 in LOAD through DONE, else 0.
REQ-015 WAIT: stay while start=1; start=0 -> IDLE; a held start SHALL NOT retrigger.
REQ-016 Invalid state encoding SHALL return to IDLE next cycle.

Reset
REQ-017 rst SHALL force IDLE, points=0, best=0, done=0, busy=0, new_record=0, accumulators cleared; rst wins over start in the same cycle.
REQ-018 rst mid-computation SHALL abort without a done pulse; the next start after rst release computes normally.

Configuration
REQ-019 Macro SCORE_ENGINE_HIGH_SCORE_EN defined: best register updated at DONE when total > best; new_record=1 with done in that cycle, else 0; ties SHALL NOT set new_record.
REQ-020 Macro undefined: best tied to 0, new_record tied to 0, no best register synthesised; all other behaviour identical.

Verification
REQ-021 level=0, cards=12, pairs=6, seconds=10 -> done at k+14, points=5656 (2323+3333+0).
REQ-022 level=1, cards=16, pairs=10, seconds=3 -> points=7979 (3333+3131+1515); Nt=1, Np=2, done at k+6.
REQ-023 level=2, cards=24, pairs=52, seconds=50 -> saturation, points=3333; done at k+69 (Nt=Np=33).
REQ-024 start held high through DONE for 20 cycles -> exactly one done; drop 1 cycle, re-raise -> second done, same points.
REQ-025 rst asserted in TIME_PEN -> next cycle busy=0, points=0, no done; following start completes correctly.
REQ-026 With SCORE_ENGINE_HIGH_SCORE_EN: runs giving 5656, then 3333, then 5656 -> new_record 1,0,0; best=5656. Without: new_record=0 and best=0 throughout.

Source files
------------

// File: rtl/score_engine.sv
// rtl/score_engine.sv - memory-game score engine: time/pair penalties, level bonus, optional high score
//
// Parameters: SCORE_W (points/best width), CARDS_W, PAIRS_W, SEC_W (input widths),
//             PENALTY (points per excess second or pair), MAX_PART (ceiling of each partial score).
// Ports:      clk, rst (synchronous, active-high)
//             start            level request to compute a score (must drop before the next run)
//             level            0 easy, 1 normal, 2 hard, 3 invalid
//             num_of_cards, discovered_pairs, seconds   game results, latched when start is accepted
//             busy             high from LOAD through DONE
//             done             one-cycle completion pulse
//             points           final score, held until the next completion
//             best, new_record best score since reset and record flag (valid with done)
// Macro:      SCORE_ENGINE_HIGH_SCORE_EN enables the best-score register and new_record;
//             without it best and new_record are constant 0.

module score_engine #(
    parameter int SCORE_W  = 14,
    parameter int CARDS_W  = 6,
    parameter int PAIRS_W  = 8,
    parameter int SEC_W    = 6,
    parameter int PENALTY  = 101,
    parameter int MAX_PART = 3333
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         level,
    input  logic [CARDS_W-1:0] num_of_cards,
    input  logic [PAIRS_W-1:0] discovered_pairs,
    input  logic [SEC_W-1:0]   seconds,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] points,
    output logic [SCORE_W-1:0] best,
    output logic               new_record
);

    // Penalty steps beyond LIMIT cannot lower a partial score further, so the
    // step counters are clamped there and the penalty phases stay bounded.
    localparam int          LIMIT   = (MAX_PART + PENALTY - 1) / PENALTY;
    localparam int          CNT_W   = $clog2(LIMIT + 1);
    localparam logic [31:0] LIMIT_V = 32'(LIMIT);
    localparam logic [SCORE_W-1:0] MP  = SCORE_W'(MAX_PART);
    localparam logic [SCORE_W-1:0] PEN = SCORE_W'(PENALTY);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        TIME_PEN = 3'd2,
        PAIR_PEN = 3'd3,
        SUM      = 3'd4,
        DONE     = 3'd5,
        WAIT     = 3'd6
    } state_t;

    state_t state, state_next;

    logic [1:0]         level_q;
    logic [CARDS_W-1:0] cards_q;
    logic [PAIRS_W-1:0] pairs_q;
    logic [SEC_W-1:0]   secs_q;
    logic [CNT_W-1:0]   cnt_t, cnt_p;
    logic [SCORE_W-1:0] acc_t, acc_p;

    logic [31:0]        grace, sec32, pairs32, half, ex_t, ex_p;
    logic [CNT_W-1:0]   cnt_t_init, cnt_p_init;
    logic [SCORE_W-1:0] bonus, time_score, pair_score, total;

    // Excess seconds/pairs from the latched game results, clamped to LIMIT.
    always_comb begin
        grace   = 32'd0;
        if (level_q == 2'd1) grace = 32'd5;
        if (level_q == 2'd2) grace = 32'd10;
        sec32   = 32'(secs_q);
        pairs32 = 32'(pairs_q);
        half    = 32'(cards_q) >> 1;
        ex_t    = (sec32 > grace)  ? sec32 - grace  : 32'd0;
        ex_p    = (pairs32 > half) ? pairs32 - half : 32'd0;
        cnt_t_init = (ex_t > LIMIT_V) ? LIMIT_V[CNT_W-1:0] : ex_t[CNT_W-1:0];
        cnt_p_init = (ex_p > LIMIT_V) ? LIMIT_V[CNT_W-1:0] : ex_p[CNT_W-1:0];
    end

    // Partial scores saturate at zero; an invalid level earns neither bonus nor time score.
    always_comb begin
        bonus      = '0;
        time_score = (acc_t >= MP) ? '0 : MP - acc_t;
        pair_score = (acc_p >= MP) ? '0 : MP - acc_p;
        case (level_q)
            2'd1:    bonus = SCORE_W'(1515);
            2'd2:    bonus = SCORE_W'(3333);
            2'd3:    time_score = '0;
            default: bonus = '0;
        endcase
        total = bonus + time_score + pair_score;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = LOAD;
            LOAD:     state_next = TIME_PEN;
            TIME_PEN: if (cnt_t <= CNT_W'(1)) state_next = PAIR_PEN;
            PAIR_PEN: if (cnt_p <= CNT_W'(1)) state_next = SUM;
            SUM:      state_next = DONE;
            DONE:     state_next = WAIT;
            WAIT:     if (!start) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            cards_q <= '0;
            pairs_q <= '0;
            secs_q  <= '0;
            cnt_t   <= '0;
            cnt_p   <= '0;
            acc_t   <= '0;
            acc_p   <= '0;
            points  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    level_q <= level;
                    cards_q <= num_of_cards;
                    pairs_q <= discovered_pairs;
                    secs_q  <= seconds;
                end
                LOAD: begin
                    cnt_t <= cnt_t_init;
                    cnt_p <= cnt_p_init;
                    acc_t <= '0;
                    acc_p <= '0;
                end
                // A zero count still spends one cycle in the phase but adds nothing.
                TIME_PEN: if (cnt_t != '0) begin
                    acc_t <= acc_t + PEN;
                    cnt_t <= cnt_t - CNT_W'(1);
                end
                PAIR_PEN: if (cnt_p != '0) begin
                    acc_p <= acc_p + PEN;
                    cnt_p <= cnt_p - CNT_W'(1);
                end
                SUM:     points <= total;
                default: ;
            endcase
        end
    end

    assign busy = (state == LOAD) || (state == TIME_PEN) || (state == PAIR_PEN) ||
                  (state == SUM)  || (state == DONE);
    assign done = (state == DONE);

`ifdef SCORE_ENGINE_HIGH_SCORE_EN
    logic [SCORE_W-1:0] best_q;
    logic               record_q;

    // Updated on the SUM->DONE edge so best and new_record line up with done.
    // Strictly greater: a tie is not a record.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q   <= '0;
            record_q <= 1'b0;
        end else begin
            record_q <= 1'b0;
            if (state == SUM && total > best_q) begin
                best_q   <= total;
                record_q <= 1'b1;
            end
        end
    end

    assign best       = best_q;
    assign new_record = record_q;
`else
    assign best       = '0;
    assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_engine.sv
// tb/tb_score_engine.sv - scoreboard bench for score_engine (default parameters)

module tb_score_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  level;
    logic [5:0]  num_of_cards;
    logic [7:0]  discovered_pairs;
    logic [5:0]  seconds;
    logic        busy;
    logic        done;
    logic [13:0] points;
    logic [13:0] best;
    logic        new_record;

    score_engine dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .level            (level),
        .num_of_cards     (num_of_cards),
        .discovered_pairs (discovered_pairs),
        .seconds          (seconds),
        .busy             (busy),
        .done             (done),
        .points           (points),
        .best             (best),
        .new_record       (new_record)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pts;
        int lat;
        int nr;
        int bst;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   best_model = 0;
    int   last_points = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference score: penalties by multiplication, saturated, plus level bonus.
    task automatic model(input int lv, input int cards, input int pairs, input int secs,
                         output int pts, output int lat);
        int grace, ex_t, ex_p, st, sp, ts, ps, bonus;
        grace = (lv == 1) ? 5 : (lv == 2) ? 10 : 0;
        ex_t  = (secs > grace) ? secs - grace : 0;
        ex_p  = (pairs > cards / 2) ? pairs - cards / 2 : 0;
        st    = (ex_t > 33) ? 33 : ex_t;
        sp    = (ex_p > 33) ? 33 : ex_p;
        ts    = (st * 101 >= 3333) ? 0 : 3333 - st * 101;
        ps    = (sp * 101 >= 3333) ? 0 : 3333 - sp * 101;
        bonus = (lv == 1) ? 1515 : (lv == 2) ? 3333 : 0;
        if (lv == 3) ts = 0;
        pts = bonus + ts + ps;
        lat = 3 + ((st < 1) ? 1 : st) + ((sp < 1) ? 1 : sp);
    endtask

    task automatic push_expected(input int pts, input int lat);
        exp_t e;
        e.pts = pts;
        e.lat = lat;
`ifdef SCORE_ENGINE_HIGH_SCORE_EN
        e.nr = (pts > best_model) ? 1 : 0;
        if (pts > best_model) best_model = pts;
        e.bst = best_model;
`else
        e.nr  = 0;
        e.bst = 0;
`endif
        sb.push_back(e);
    endtask

    // One game. exp_pts < 0 takes the expectation from the model. start stays
    // high through DONE and for 'hold' further cycles, then drops.
    task automatic run_game(input int lv, input int cards, input int pairs, input int secs,
                            input int hold, input int exp_pts, input int exp_lat);
        int   m_pts, m_lat, edges, extra;
        bit   seen;
        exp_t e;
        model(lv, cards, pairs, secs, m_pts, m_lat);
        if (exp_pts < 0) begin
            exp_pts = m_pts;
            exp_lat = m_lat;
        end
        @(negedge clk);
        level            = 2'(lv);
        num_of_cards     = 6'(cards);
        discovered_pairs = 8'(pairs);
        seconds          = 6'(secs);
        start            = 1'b1;
        push_expected(exp_pts, exp_lat);
        @(posedge clk);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 150) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                check("busy_running", int'(busy), 1);
                check("points_held", int'(points), last_points);
            end
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("points", int'(points), e.pts);
                check("latency", edges + 1, e.lat);
                check("new_record", int'(new_record), e.nr);
                check("best", int'(best), e.bst);
                last_points = e.pts;
            end else begin
                // Inputs must be ignored while the engine runs.
                level            = 2'($urandom_range(0, 3));
                num_of_cards     = 6'($urandom_range(0, 63));
                discovered_pairs = 8'($urandom_range(0, 255));
                seconds          = 6'($urandom_range(0, 63));
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        if (hold > 0) check("held_start_retrigger", extra, 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        if (hold == 0) begin
            @(posedge clk);
            #1;
        end
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        start = 1'b1;
        level = 2'd0;
        num_of_cards = '0;
        discovered_pairs = '0;
        seconds = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_points", int'(points), 0);
        check("rst_best", int'(best), 0);
        check("rst_new_record", int'(new_record), 0);
        start = 1'b0;
        rst = 1'b0;

        run_game(0, 12, 6, 10, 0, 5656, 14);
        run_game(1, 16, 10, 3, 0, 7979, 6);
        run_game(2, 24, 52, 50, 0, 3333, 69);
        run_game(3, 10, 7, 20, 0, -1, 0);
        run_game(1, 16, 10, 3, 20, 7979, 6);
        run_game(1, 16, 10, 3, 0, 7979, 6);

        // Reset during TIME_PEN aborts without a done pulse.
        @(negedge clk);
        level = 2'd2;
        num_of_cards = 6'd24;
        discovered_pairs = 8'd52;
        seconds = 6'd50;
        start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_points", int'(points), 0);
        check("abort_done", int'(done), 0);
        check("abort_best", int'(best), 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        best_model = 0;
        last_points = 0;

        run_game(0, 12, 6, 10, 0, 5656, 14);
        run_game(2, 24, 52, 50, 0, 3333, 69);
        run_game(0, 12, 6, 10, 0, 5656, 14);

        for (int i = 0; i < 8; i++)
            run_game($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 80),
                     $urandom_range(0, 63), $urandom_range(0, 2), -1, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
